key_debounce: RTL and testbench



---
 rtl/key_pkg.sv | 25 ++
 rtl/key_debounce_ch.sv | 108 ++++++++++
 rtl/key_debounce.sv | 30 +++
 tb/tb_key_debounce.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the push-button debouncer: channel FSM states,
// a constant-width helper and the default stability window.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_fsm_t;

  // 20 ms of stability at 50 MHz.
  localparam int DEBOUNCE_CYC_DEFAULT = 1_000_000;

  // Bits needed to count 0 .. value-1; never less than 1.
  function automatic int clog2_width(input int value);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: two-flop synchronizer on the active-low pin, then a
// four-state FSM that accepts a level only after DEBOUNCE_CYC stable cycles.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release
);

  localparam int CNT_W = clog2_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             key_pressed;
  key_fsm_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  assign key_pressed = ~sync2_q;

  always_comb begin
    sync1_d   = key_in;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          press_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!key_pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (key_pressed) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Synchronizer resets to the released pin level (high) so a held key is
  // re-qualified from scratch after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_state   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer feeding the LED stage: KEY_W independent channels,
// each giving a clean level plus one-cycle press and release pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter int KEY_W        = 4,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release
);

  for (genvar i = 0; i < KEY_W; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .key_in     (key_in[i]),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed latency/bounce/reset scenarios plus random
// key activity, all compared cycle by cycle against a run-length model.
module tb_key_debounce;

  localparam int KEY_W   = 4;
  localparam int DEB     = 8;
  localparam int CNT_MAX = DEB - 1;
  localparam int OUT_W   = 3 * KEY_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [KEY_W-1:0] key_in;
  logic [KEY_W-1:0] key_state;
  logic [KEY_W-1:0] key_press;
  logic [KEY_W-1:0] key_release;

  always #5 clk = ~clk;

  key_debounce #(
    .KEY_W       (KEY_W),
    .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference: a key's accepted level flips once its pin (seen two samples
  // late) has disagreed with that level for DEB+1 consecutive edges.
  logic [OUT_W-1:0] exp_q[$];
  logic [KEY_W-1:0] pin_q[$];
  logic [KEY_W-1:0] lvl;
  int               run [KEY_W];

  int edge_no;
  int press_cnt [KEY_W];
  int rel_cnt   [KEY_W];
  int press_edge[KEY_W];
  int rel_edge  [KEY_W];
  int hold_left [KEY_W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [KEY_W-1:0] s, pv, rv;
    if (rst) begin
      pin_q.delete();
      pin_q.push_back('0);
      pin_q.push_back('0);
      lvl = '0;
      for (int c = 0; c < KEY_W; c++) run[c] = 0;
      exp_q.push_back('0);
    end else begin
      s  = pin_q.pop_front();
      pin_q.push_back(~key_in);
      pv = '0;
      rv = '0;
      for (int c = 0; c < KEY_W; c++) begin
        if (s[c] != lvl[c]) begin
          run[c]++;
          if (run[c] == DEB + 1) begin
            lvl[c] = s[c];
            run[c] = 0;
            if (s[c]) pv[c] = 1'b1;
            else      rv[c] = 1'b1;
          end
        end else begin
          run[c] = 0;
        end
      end
      exp_q.push_back({lvl, pv, rv});
    end
  endtask

  task automatic tick();
    logic [OUT_W-1:0] exp;
    @(posedge clk);
    model_edge();
    #1;
    edge_no++;
    exp = exp_q.pop_front();
    check("outs", 32'({key_state, key_press, key_release}), 32'(exp));
    check("excl", 32'(key_press & key_release), 32'd0);
    for (int c = 0; c < KEY_W; c++) begin
      if (key_press[c]) begin
        press_cnt[c]++;
        if (press_edge[c] < 0) press_edge[c] = edge_no;
      end
      if (key_release[c]) begin
        rel_cnt[c]++;
        if (rel_edge[c] < 0) rel_edge[c] = edge_no;
      end
    end
  endtask

  task automatic clear_stats();
    edge_no = 0;
    for (int c = 0; c < KEY_W; c++) begin
      press_cnt[c]  = 0;
      rel_cnt[c]    = 0;
      press_edge[c] = -1;
      rel_edge[c]   = -1;
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst    = 1'b1;
    key_in = '1;
    lvl    = '0;
    clear_stats();
    hold(3);
    check("reset_outs", 32'({key_state, key_press, key_release}), 32'd0);
    rst = 1'b0;
    hold(2);

    // Clean press on key 0.
    clear_stats();
    key_in[0] = 1'b0;
    hold(16);
    check("press_edge0", 32'(press_edge[0]), 32'(CNT_MAX + 4));
    check("press_cnt0", 32'(press_cnt[0]), 32'd1);
    check("state_after_press", 32'(key_state), 32'b0001);
    check("others_quiet", 32'(press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'd0);

    // Bounce on key 1: low 5, high 2, low 4, high.
    clear_stats();
    key_in[1] = 1'b0; hold(5);
    key_in[1] = 1'b1; hold(2);
    key_in[1] = 1'b0; hold(4);
    key_in[1] = 1'b1; hold(16);
    check("bounce_press1", 32'(press_cnt[1]), 32'd0);
    check("bounce_state1", 32'(key_state[1]), 32'd0);

    // Clean release of key 0.
    clear_stats();
    key_in[0] = 1'b1;
    hold(16);
    check("rel_edge0", 32'(rel_edge[0]), 32'(CNT_MAX + 4));
    check("rel_cnt0", 32'(rel_cnt[0]), 32'd1);
    check("state_after_rel", 32'(key_state[0]), 32'd0);

    // Release bounce of 3 cycles while held.
    key_in[0] = 1'b0;
    hold(16);
    clear_stats();
    key_in[0] = 1'b1; hold(3);
    key_in[0] = 1'b0; hold(16);
    check("rel_bounce_cnt", 32'(rel_cnt[0]), 32'd0);
    check("rel_bounce_state", 32'(key_state[0]), 32'd1);
    key_in = '1;
    hold(16);

    // All four keys at once.
    clear_stats();
    key_in = '0;
    hold(16);
    for (int c = 0; c < KEY_W; c++) begin
      check("simul_edge", 32'(press_edge[c]), 32'(CNT_MAX + 4));
      check("simul_cnt", 32'(press_cnt[c]), 32'd1);
    end
    key_in = '1;
    hold(16);

    // Key 2 staggered by three cycles.
    clear_stats();
    key_in = 4'b0100;
    hold(3);
    key_in = 4'b0000;
    hold(20);
    check("stagger_delta", 32'(press_edge[2] - press_edge[0]), 32'd3);
    key_in = '1;
    hold(16);

    // Reset while key 3 is mid-qualification (cnt=5 after edge 8).
    clear_stats();
    key_in[3] = 1'b0;
    hold(8);
    rst = 1'b1;
    tick();
    check("mid_rst_outs", 32'({key_state, key_press, key_release}), 32'd0);
    rst = 1'b0;
    clear_stats();
    hold(16);
    check("post_rst_edge3", 32'(press_edge[3]), 32'(CNT_MAX + 4));
    check("post_rst_cnt3", 32'(press_cnt[3]), 32'd1);
    key_in = '1;
    hold(16);

    // Long hold on key 0.
    clear_stats();
    key_in[0] = 1'b0;
    hold(1000);
    check("long_cnt0", 32'(press_cnt[0]), 32'd1);
    check("long_state0", 32'(key_state[0]), 32'd1);
    key_in = '1;
    hold(16);

    // Random activity with occasional resets.
    for (int c = 0; c < KEY_W; c++) hold_left[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < KEY_W; c++) begin
        if (hold_left[c] == 0) begin
          key_in[c]    = 1'($urandom_range(0, 1));
          hold_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 30))
                                                     : int'($urandom_range(1, 6));
        end
        hold_left[c]--;
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
